// File: rtl/present_player_pipe.sv
// PRESENT pLayer bit permutation feeding a 2-entry valid/ready skid buffer.
// Define PRESENT_PLAYER_INV_EN to build the per-word inverse permutation selected by in_inv.
module present_player_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_inv
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_perm;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  // Bit i of the input lands on bit P(i); the top bit is a fixed point of the map.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_fwd
    localparam int P = (gi * (WIDTH / 4)) % (WIDTH - 1);
    assign w_fwd[P] = in_data[gi];
  end
  assign w_fwd[WIDTH-1] = in_data[WIDTH-1];

`ifdef PRESENT_PLAYER_INV_EN
  logic [WIDTH-1:0] w_inv;
  logic             r_main_inv;
  logic             r_skid_inv;

  for (genvar gj = 0; gj < WIDTH - 1; gj++) begin : g_inv
    localparam int P = (gj * (WIDTH / 4)) % (WIDTH - 1);
    assign w_inv[gj] = in_data[P];
  end
  assign w_inv[WIDTH-1] = in_data[WIDTH-1];
  assign w_perm         = in_inv ? w_inv : w_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_inv <= 1'b0;
      r_skid_inv <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_inv <= in_inv;
      end else if (w_skid_to_main) begin
        r_main_inv <= r_skid_inv;
      end
      if (w_load_skid) begin
        r_skid_inv <= in_inv;
      end
    end
  end
  assign out_inv = r_main_inv;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_perm       = w_fwd;
  assign out_inv      = 1'b0;
`endif

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = HALF;
          w_load_main = 1'b1;
        end
      end
      HALF: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_state_nxt = EMPTY;
        end else if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_state_nxt    = HALF;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_perm;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_data <= w_perm;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;

endmodule

// File: tb/tb_present_player_pipe.sv
// Self-checking bench for present_player_pipe: vector table, backpressure, random scoreboard,
// async reset and a WIDTH=16 instance, against a bit-loop reference of the permutation rule.
module tb_present_player_pipe;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
  logic [W-1:0]  in_data, out_data;
  logic          v16, rdy16, i16, ov16, or16, oi16;
  logic [15:0]   d16, od16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  present_player_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inv(out_inv));

  present_player_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(d16),
    .in_inv(i16), .out_valid(ov16), .out_ready(or16), .out_data(od16), .out_inv(oi16));

  task automatic checkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_inv(input logic inv);
`ifdef PRESENT_PLAYER_INV_EN
    return inv;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: forward puts bit i at P(i); inverse pulls bit P(i) into bit i.
  function automatic logic [127:0] exp_word(input logic [127:0] d, input logic inv, input int w);
    logic [127:0] r;
    int p;
    r = '0;
    for (int i = 0; i < w; i++) begin
      p = (i == w - 1) ? i : ((i * w / 4) % (w - 1));
      if (exp_inv(inv)) r[i] = d[p];
      else              r[p] = d[i];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         inv;
    logic [W-1:0] ed;
    logic         ei;
  } vec_t;

  vec_t tv[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] w0, w1, x, y, last;
    logic [W:0]   q[$];
    int sent, recv, cyc, nvalid;
    bit stalled;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    v16 = 1'b0; d16 = 16'h0000; i16 = 1'b0; or16 = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkw("rst_in_ready", 128'(in_ready), 128'(0));
    checkw("rst_out_valid", 128'(out_valid), 128'(0));
    checkw("rst_out_data", 128'(out_data), 128'(0));
    checkw("rst_out_inv", 128'(out_inv), 128'(0));
    @(posedge clk);
    tick();
    rst = 1'b0;
    checkw("ready_low_until_edge", 128'(in_ready), 128'(0));
    tick();
    checkw("ready_after_rst", 128'(in_ready), 128'(1));
    checkw16: checkw("w16_ready_after_rst", 128'(rdy16), 128'(1));

    tv[0] = '{64'h0000_0000_0000_0002, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    tv[1] = '{64'h0000_0000_0000_0010, 1'b0, 64'h0000_0000_0000_0002, 1'b0};
    tv[2] = '{64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    tv[3] = '{64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, 1'b0};
    tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tv[5] = '{64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b0};
`ifdef PRESENT_PLAYER_INV_EN
    tv[6] = '{64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0002, 1'b1};
`else
    tv[6] = '{64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0010, 1'b0};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = tv[i].d; in_inv = tv[i].inv;
      tick();
      checkw("vec_valid", 128'(out_valid), 128'(1));
      checkw("vec_data", 128'(out_data), 128'(tv[i].ed));
      checkw("vec_inv", 128'(out_inv), 128'(tv[i].ei));
      checkw("vec_ready", 128'(in_ready), 128'(1));
    end
    in_valid = 1'b0; in_inv = 1'b0;
    tick();
    checkw("vec_drained", 128'(out_valid), 128'(0));

    // Backpressure: two words stall, then leave in order.
    w0 = rnd64(); w1 = rnd64();
    out_ready = 1'b0; in_valid = 1'b1; in_data = w0;
    tick();
    in_data = w1;
    tick();
    in_valid = 1'b0;
    checkw("bp_full_ready", 128'(in_ready), 128'(0));
    checkw("bp_valid", 128'(out_valid), 128'(1));
    checkw("bp_w0", 128'(out_data), exp_word(128'(w0), 1'b0, W));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkw("bp_stable", 128'(out_data), exp_word(128'(w0), 1'b0, W));
    end
    out_ready = 1'b1;
    tick();
    checkw("bp_w1", 128'(out_data), exp_word(128'(w1), 1'b0, W));
    checkw("bp_ready_back", 128'(in_ready), 128'(1));
    tick();
    checkw("bp_empty", 128'(out_valid), 128'(0));

    // Full-rate streaming: one word out every cycle, 1-cycle latency.
    nvalid = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = rnd64();
      if (!in_ready) nvalid = -100;
      tick();
      if (out_valid) nvalid++;
      checkw("tput_data", 128'(out_data), exp_word(128'(in_data), 1'b0, W));
    end
    checkw("tput_count", 128'(nvalid), 128'(20));
    in_valid = 1'b0;
    tick();

    // Random valid/ready against a queue scoreboard.
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; last = '0;
    while ((sent < 256 || q.size() > 0) && cyc < 4000) begin
      in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
      in_data   = rnd64();
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkw("sb_spurious", 128'(1), 128'(0));
        end else begin
          checkw("sb_word", 128'({out_inv, out_data}), 128'(q[0]));
          void'(q.pop_front());
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      last    = out_data;
      if (in_valid && in_ready) begin
        x = W'(exp_word(128'(in_data), in_inv, W));
        q.push_back({exp_inv(in_inv), x});
        sent++;
      end
      tick();
      cyc++;
      if (stalled) checkw("sb_stall_stable", 128'(out_data), 128'(last));
    end
    checkw("sb_no_timeout", 128'(cyc < 4000), 128'(1));
    checkw("sb_recv", 128'(recv), 128'(256));
    in_valid = 1'b0; out_ready = 1'b1; in_inv = 1'b0;
    tick();

    // Forward then inverse-flagged pass on 1000 random words.
    for (int k = 0; k < 1000; k++) begin
      x = rnd64();
      in_valid = 1'b1; in_data = x; in_inv = 1'b0;
      tick();
      y = out_data;
      checkw("rt_fwd", 128'(y), exp_word(128'(x), 1'b0, W));
      in_data = y; in_inv = 1'b1;
      tick();
      checkw("rt_inv", 128'(out_data), exp_word(128'(y), 1'b1, W));
      checkw("rt_inv_flag", 128'(out_inv), 128'(exp_inv(1'b1)));
`ifdef PRESENT_PLAYER_INV_EN
      checkw("rt_identity", 128'(out_data), 128'(x));
`endif
    end
    in_valid = 1'b0; in_inv = 1'b0;
    tick();

    // Asynchronous reset while both entries are occupied.
    out_ready = 1'b0; in_valid = 1'b1; in_data = rnd64(); in_inv = 1'b1;
    tick();
    in_data = rnd64();
    tick();
    in_valid = 1'b0;
    checkw("ar_full", 128'(in_ready), 128'(0));
    #2 rst = 1'b1;
    #1;
    checkw("ar_valid", 128'(out_valid), 128'(0));
    checkw("ar_data", 128'(out_data), 128'(0));
    checkw("ar_inv", 128'(out_inv), 128'(0));
    checkw("ar_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checkw("ar_ready_back", 128'(in_ready), 128'(1));
    checkw("ar_discarded", 128'(out_valid), 128'(0));

    // WIDTH=16 instance.
    v16 = 1'b1; d16 = 16'h0002; i16 = 1'b0;
    tick();
    checkw("w16_valid", 128'(ov16), 128'(1));
    checkw("w16_vec", 128'(od16), 128'(16'h0010));
    for (int k = 0; k < 20; k++) begin
      d16 = 16'($urandom); i16 = 1'($urandom_range(0, 1));
      tick();
      checkw("w16_rand", 128'(od16), exp_word(128'(d16), i16, 16));
      checkw("w16_inv", 128'(oi16), 128'(exp_inv(i16)));
    end
    v16 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
